data_memory_responder: RTL



---
 rtl/data_memory_responder.sv | 79 +++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle MEM-stage word memory that stalls the pipeline until each access completes.
// Ports: clk; reset (async, active-low); mem_read_input / mem_write_input / address_input / write_data_input
// come from the EX/MEM register; read_data_output + read_valid_output feed MEM/WB; stall_request_output holds
// the pipeline; error_output is a sticky misaligned / out-of-range / read+write flag.
module data_memory_responder #(
  parameter int DEPTH_WORDS  = 256,
  parameter int STALL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_input,
  input  logic        mem_write_input,
  input  logic [31:0] address_input,
  input  logic [31:0] write_data_input,
  output logic [31:0] read_data_output,
  output logic        read_valid_output,
  output logic        stall_request_output,
  output logic        error_output
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (STALL_CYCLES >= 2) ? 4'(STALL_CYCLES - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic valid_q, err_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic req, bad, acc;
  logic [AW-1:0] idx;
  assign req = mem_read_input | mem_write_input;
  assign idx = address_input[AW+1:2];
  assign bad = (|address_input[1:0]) || (|(address_input >> (AW + 2))) || (mem_read_input && mem_write_input);
  // The access edge; gated by reset so an IDLE request held during reset never writes memory.
  assign acc = reset && ((state_q == IDLE && req && STALL_CYCLES == 1) || (state_q == WAIT && cnt_q == 4'd0));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = (STALL_CYCLES == 1) ? RESP : WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    stall_request_output = reset && ((state_q == IDLE && req) || state_q == WAIT);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (acc) begin
      rdata_q <= bad ? 32'd0 : (mem_read_input ? mem[idx] : rdata_q);
      valid_q <= !bad && mem_read_input;
      err_q   <= err_q | bad;
    end else begin
      valid_q <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (acc && !bad && mem_write_input) mem[idx] <= write_data_input;
  end
  assign read_data_output  = rdata_q;
  assign read_valid_output = valid_q;
  assign error_output      = err_q;
endmodule
